mb_deser: RTL and testbench
===========================

// Module: mb_deser
// PURPOSE
//  Inverse of the macroblock serializer: collects the per-coefficient stream (sign, 6-bit pos, last flag)
//  back into one macroblock word (sign[63:0], pos[63:0][5:0], size) and writes it to the downstream MB FIFO.
//  Sits after the serial coefficient path. Drives an almost-full back to the serializer so no element is lost.
// PARAMETERS
//  MB_MAX   64  max coefficients per macroblock (pos entries); only 64 supported, sizes MB word
//  POS_W    6   position field width
// PORTS
//  clk            in   1            clock
//  rst            in   1            asynchronous, active-low reset
//  clk_en         in   1            global clock enable; all state holds when low
//  sign_in        in   1            coefficient sign
//  pos_in         in   7            {last_in_mb, pos[5:0]}
//  in_wr          in   1            element valid this cycle (honoured only with clk_en)
//  slice_end_in   in   1            pulse: the most recently closed MB ends the slice
//  mb_full        in   1            downstream MB FIFO full
//  in_afull       out  1            back-pressure to serializer (combinational)
//  mb_wr          out  1            MB FIFO write strobe (combinational)
//  sign_out       out  64           assembled signs, first element at bit 63
//  pos_out        out  64x6         assembled positions, first element at index 63
//  size_out       out  7            element count 1..64
//  slice_end_out  out  1            one-cycle pulse, ordered after the MB it belongs to
//  proto_err      out  1            sticky protocol error (MB_DESER_ERR_EN only)
// BEHAVIOUR
//  Reset: all registers and outputs 0; asm/out buffers empty; cnt=0.
//  Assembly buffer (asm_sign, asm_pos, cnt[6:0]): accepted element k (k=cnt) is written to index 63-k; cnt+1.
//   Unused entries are 0: the buffer clears on close.
//  Accept = clk_en && in_wr && ~(out_valid && ~mb_wr). Non-accepted in_wr is dropped (error, see CONFIGURATION).
//  Close: accepted element with pos_in[6]=1, or accepted with cnt==63 (forced close, size 64).
//   On close: out buffer <= asm data incl. this element, size_out <= cnt+1, out_valid<=1; asm cleared, cnt<=0.
//   Forced close without last flag = protocol error.
//  Output: mb_wr = clk_en && out_valid && ~mb_full. out_* stable while out_valid.
//   out_valid clears after mb_wr, except when a close happens in the same cycle (reload, stays 1).
//  in_afull = (out_valid && ~mb_wr) || close_this_cycle.
//   The serializer samples afull before issuing its registered write, so no element arrives while out is held.
//  Latency: last element at cycle t -> out_valid at t+1 -> mb_wr at t+1 if ~mb_full.
//  Slice end: slice_end_in sets se_pend.
//   slice_end_out pulses for one clk_en cycle when se_pend && ~out_valid; se_pend then clears.
//   If se_pend is set while out_valid, the pulse follows the cycle after that MB's mb_wr.
//   slice_end_in arriving while se_pend is already set is merged into the pending pulse (error).
//  slice_end_in with cnt!=0 (mid-MB): pulse still deferred as above; partial MB is unaffected.
//  Reset mid-MB discards asm and out contents; no mb_wr issued.
//  Empty MBs (size 0) are never produced.
// CONFIGURATION
//  MB_DESER_ERR_EN defined: proto_err set (sticky until reset) on:
//   - dropped in_wr
//   - forced close at 64 without last flag
//   - slice_end_in while se_pend
//  MB_DESER_ERR_EN undefined: proto_err tied 0, no detection logic; data-path behaviour identical.
// STRUCTURE
//  mb_pkg: MB_MAX, POS_W, typedef logic [POS_W-1:0] mb_pos_t;
//   typedef struct packed {sign[63:0]; mb_pos_t [63:0] pos; size[6:0]} mb_word_t.
//  Single module; asm and out buffers are two mb_word_t registers. No sub-module warranted.
// TESTING
//  1 3 elements (s=1,p=5),(0,9),(1,63 last), mb_full=0
//    -> mb_wr one cycle after last; size=3, sign[63:61]=101, pos[63]=5, pos[62]=9, pos[61]=63, rest 0.
//  2 Single element (0,0,last)
//    -> size=1, all sign bits 0; in_afull high in the close cycle only.
//  3 Close while mb_full=1 for 5 cycles
//    -> in_afull held, mb_wr exactly once after mb_full drops, data unchanged.
//  4 64 elements, last flag only on 64th
//    -> size=64, no error. Same with no last flag -> size=64, proto_err=1 (ERR_EN).
//  5 slice_end_in 2 cycles after last while mb_full=1
//    -> slice_end_out pulses the cycle after mb_wr, not before.
//  6 Assert rst mid-MB (cnt=10), resume with 2-element MB
//    -> size=2, no stale data; clk_en=0 cycles freeze all state and suppress mb_wr.

Source files
------------

// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared macroblock word types for the coefficient deserializer
package mb_pkg;

    localparam int MB_MAX = 64;
    localparam int POS_W  = 6;

    typedef logic [POS_W-1:0] mb_pos_t;

    // One assembled macroblock; element 0 lives at index MB_MAX-1.
    typedef struct packed {
        logic [MB_MAX-1:0]    sign;
        mb_pos_t [MB_MAX-1:0] pos;
        logic [6:0]           size;
    } mb_word_t;

endpackage

// File: rtl/mb_deser.sv
// rtl/mb_deser.sv - coefficient stream to macroblock word assembler (optional MB_DESER_ERR_EN)
module mb_deser
    import mb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 sign_in,
    input  logic [6:0]           pos_in,
    input  logic                 in_wr,
    input  logic                 slice_end_in,
    input  logic                 mb_full,
    output logic                 in_afull,
    output logic                 mb_wr,
    output logic [MB_MAX-1:0]    sign_out,
    output mb_pos_t [MB_MAX-1:0] pos_out,
    output logic [6:0]           size_out,
    output logic                 slice_end_out,
    output logic                 proto_err
);

    // asm_q.size doubles as the running element count of the open MB
    mb_word_t asm_q, asm_d;
    mb_word_t out_q, out_d;
    logic     out_valid_q, out_valid_d;
    logic     se_pend_q, se_pend_d;

    logic     hold;
    logic     accept;
    logic     close;
    logic     se_fire;
    logic [5:0] idx;
    mb_word_t asm_fill;

    assign mb_wr         = clk_en && out_valid_q && !mb_full;
    assign hold          = out_valid_q && !mb_wr;
    assign accept        = clk_en && in_wr && !hold;
    assign close         = accept && (pos_in[6] || (asm_q.size == 7'd63));
    assign in_afull      = hold || close;
    assign se_fire       = clk_en && se_pend_q && !out_valid_q;
    assign slice_end_out = se_fire;

    assign sign_out = out_q.sign;
    assign pos_out  = out_q.pos;
    assign size_out = out_q.size;

    // Next-state for assembly/output buffers and the pending slice-end flag
    always_comb begin
        idx      = ~asm_q.size[5:0];
        asm_fill = asm_q;
        asm_fill.sign[idx] = sign_in;
        asm_fill.pos[idx]  = pos_in[5:0];
        asm_fill.size      = asm_q.size + 7'd1;

        asm_d = asm_q;
        out_d = out_q;
        if (accept) begin
            // closing hands the filled word to the output and starts a clean buffer
            asm_d = close ? '0 : asm_fill;
        end
        if (close) begin
            out_d = asm_fill;
        end

        // a close in the same cycle as mb_wr reloads the output without a gap
        out_valid_d = close || (out_valid_q && !mb_wr);

        // a slice end arriving while one is pending merges into it
        if (se_pend_q) begin
            se_pend_d = !se_fire;
        end else begin
            se_pend_d = slice_end_in;
        end
    end

    // State registers; everything freezes while clk_en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            se_pend_q   <= 1'b0;
        end else if (clk_en) begin
            asm_q       <= asm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            se_pend_q   <= se_pend_d;
        end
    end

`ifdef MB_DESER_ERR_EN
    logic err_q, err_d;

    // Sticky error: dropped write, forced close at 64 without last, merged slice end
    always_comb begin
        err_d = err_q
             || (clk_en && in_wr && !accept)
             || (close && !pos_in[6])
             || (clk_en && slice_end_in && se_pend_q);
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (clk_en) begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mb_deser.sv
// tb/tb_mb_deser.sv - scoreboard bench for mb_deser
module tb_mb_deser;
    import mb_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clk_en = 1'b1;
    logic                 sign_in = 1'b0;
    logic [6:0]           pos_in = '0;
    logic                 in_wr = 1'b0;
    logic                 slice_end_in = 1'b0;
    logic                 mb_full = 1'b0;
    logic                 in_afull;
    logic                 mb_wr;
    logic [63:0]          sign_out;
    mb_pos_t [63:0]       pos_out;
    logic [6:0]           size_out;
    logic                 slice_end_out;
    logic                 proto_err;

    mb_deser dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sign_in(sign_in), .pos_in(pos_in),
        .in_wr(in_wr), .slice_end_in(slice_end_in), .mb_full(mb_full),
        .in_afull(in_afull), .mb_wr(mb_wr), .sign_out(sign_out), .pos_out(pos_out),
        .size_out(size_out), .slice_end_out(slice_end_out), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      s;
        logic [63:0][5:0] p;
        logic [6:0]       n;
    } exp_t;

    exp_t sb[$];
    int tot = 0;
    int bad = 0;
    int wr_cnt = 0;
    int push_cnt = 0;
    logic [63:0]      m_s = '0;
    logic [63:0][5:0] m_p = '0;
    int               m_n = 0;
    logic             exp_err = 1'b0;
    logic             last_af = 1'b0;
    int               w0;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_s = '0;
        m_p = '0;
        m_n = 0;
    endtask

    task automatic model_push(input logic s, input logic [5:0] p, input logic last);
        m_s[63 - m_n] = s;
        m_p[63 - m_n] = p;
        m_n++;
        if (last || m_n == 64) begin
            sb.push_back('{s: m_s, p: m_p, n: 7'(m_n)});
            push_cnt++;
            if (!last) exp_err = 1'b1;
            model_clear();
        end
    endtask

    // issue one element once afull is low; records afull seen in the issue cycle
    task automatic send(input logic s, input logic [5:0] p, input logic last);
        int g = 0;
        #1;
        while (in_afull && g < 100) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 100) chk("afull_timeout", 1, 0);
        sign_in = s;
        pos_in  = {last, p};
        in_wr   = 1'b1;
        model_push(s, p, last);
        @(negedge clk);
        last_af = in_afull;
        @(posedge clk); #1;
        in_wr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // scoreboard check on every MB write
    always @(negedge clk) begin
        if (mb_wr) begin
            exp_t e;
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("size", size_out, e.n);
                chk("sign", sign_out, e.s);
                chk("pos", pos_out, e.p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_mb_wr", mb_wr, 0);
        chk("rst_afull", in_afull, 0);
        chk("rst_size", size_out, 0);
        chk("rst_sign", sign_out, 0);
        chk("rst_se_out", slice_end_out, 0);
        chk("rst_err", proto_err, 0);
        cyc();

        // 1: three-element MB, one-cycle latency
        send(1'b1, 6'd5, 1'b0);
        send(1'b0, 6'd9, 1'b0);
        send(1'b1, 6'd63, 1'b1);
        @(negedge clk);
        chk("t1_latency", mb_wr, 1);
        cyc();

        // 2: single element, afull only in the close cycle
        @(negedge clk);
        chk("t2_afull_pre", in_afull, 0);
        cyc();
        send(1'b0, 6'd0, 1'b1);
        chk("t2_afull_close", last_af, 1);
        @(negedge clk);
        chk("t2_afull_post", in_afull, 0);
        chk("t2_wr", mb_wr, 1);
        cyc();

        // 3: close while downstream full for 5 cycles
        mb_full = 1'b1;
        w0 = wr_cnt;
        send(1'b1, 6'd7, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("t3_afull_held", in_afull, 1);
            chk("t3_no_wr", mb_wr, 0);
            cyc();
        end
        mb_full = 1'b0;
        repeat (3) cyc();
        chk("t3_wr_once", wr_cnt - w0, 1);

        // 5: slice end two cycles after last while full
        mb_full = 1'b1;
        send(1'b0, 6'd12, 1'b1);
        cyc();
        slice_end_in = 1'b1;
        cyc();
        slice_end_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_se_early", slice_end_out, 0);
            cyc();
        end
        mb_full = 1'b0;
        @(negedge clk);
        chk("t5_wr", mb_wr, 1);
        chk("t5_se_with_wr", slice_end_out, 0);
        cyc();
        @(negedge clk);
        chk("t5_se_pulse", slice_end_out, 1);
        cyc();
        @(negedge clk);
        chk("t5_se_once", slice_end_out, 0);
        cyc();

        // 4: full 64-element MBs, with and without last flag
        for (int i = 0; i < 64; i++) send(i[0], 6'(i), i == 63);
        repeat (2) cyc();
        @(negedge clk);
        chk("t4_err_clean", proto_err, 0);
        cyc();
        for (int i = 0; i < 64; i++) send(~i[0], 6'(63 - i), 1'b0);
        repeat (2) cyc();
        @(negedge clk);
`ifdef MB_DESER_ERR_EN
        chk("t4_err_forced", proto_err, exp_err);
`else
        chk("t4_err_forced", proto_err, 0);
`endif
        cyc();

        // 6: reset mid-MB, then a 2-element MB with clk_en stalls
        for (int i = 0; i < 10; i++) send(1'b1, 6'(i + 20), 1'b0);
        rst = 1'b0;
        model_clear();
        exp_err = 1'b0;
        @(negedge clk);
        chk("t6_rst_wr", mb_wr, 0);
        chk("t6_rst_err", proto_err, 0);
        cyc();
        rst = 1'b1;
        cyc();
        send(1'b1, 6'd33, 1'b0);
        clk_en = 1'b0;
        repeat (2) cyc();
        clk_en = 1'b1;
        send(1'b0, 6'd44, 1'b1);
        clk_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_clken_no_wr", mb_wr, 0);
            cyc();
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("t6_wr", mb_wr, 1);
        cyc();

        repeat (5) cyc();
        chk("sb_empty", sb.size(), 0);
        chk("wr_total", wr_cnt, push_cnt);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
